// File: rtl/tiny16_intc_pkg.sv
// Shared definitions for the tiny16 interrupt controller: register offsets,
// VECTOR layout and the lowest-index priority helper.
package tiny16_intc_pkg;

    typedef enum logic [1:0] {
        INTC_PENDING = 2'd0,
        INTC_MASK    = 2'd1,
        INTC_EDGE    = 2'd2,
        INTC_VECTOR  = 2'd3
    } intc_reg_e;

    localparam int unsigned INTC_VALID_BIT = 15;

    // Returns {found, index} of the lowest-numbered set bit.
    function automatic logic [4:0] lowest_set(input logic [15:0] v);
        logic       found;
        logic [3:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i] && !found) begin
                found = 1'b1;
                idx   = 4'(i);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/tiny16_irq_sync.sv
// Per-source two-flop synchroniser plus history flop; rise flags a
// synchronised 0->1 transition for one cycle.
module tiny16_irq_sync (
    input  logic clk,
    input  logic nreset,
    input  logic req,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s2_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1   <= req;
            s2   <= s1;
            s2_q <= s2;
        end
    end

    assign rise = s2 & ~s2_q;

endmodule

// File: rtl/tiny16_intc.sv
// Memory-mapped interrupt controller for the tiny16 core: edge/level
// sources, mask, W1C pending and a priority VECTOR whose read acknowledges.
module tiny16_intc
    import tiny16_intc_pkg::*;
#(
    parameter int unsigned N_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [15:0]      address,
    input  logic [15:0]      wdata,
    input  logic             nrd,
    input  logic             nwr,
    output logic [15:0]      rdata,
    output logic             sel,
    input  logic [N_IRQ-1:0] irq,
    output logic             interrupt
);

    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] edge_en;
    logic [N_IRQ-1:0] latch;
    logic [N_IRQ-1:0] s2;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] clr;
    logic             nrd_q;
    logic             nwr_q;
    logic             wr_ev;
    logic             ack_ev;
    logic             valid;
    logic [3:0]       idx;
    intc_reg_e        offset;
    logic             unused_wdata;

    genvar g;
    for (g = 0; g < N_IRQ; g++) begin : g_sync
        tiny16_irq_sync u_sync (
            .clk    (clk),
            .nreset (nreset),
            .req    (irq[g]),
            .s2     (s2[g]),
            .rise   (rise[g])
        );
    end

    assign sel    = (address[15:2] == BASE_ADDR[15:2]);
    assign offset = intc_reg_e'(address[1:0]);

    assign pending   = (edge_en & latch) | (~edge_en & s2);
    assign active    = pending & mask;
    assign {valid, idx} = lowest_set(16'(active));
    assign interrupt = |active;

    // Strobe falling edge detected against the registered copy: one event per access.
    assign wr_ev  = sel & ~nwr & nwr_q;
    assign ack_ev = sel & ~nrd & nrd_q & (offset == INTC_VECTOR) & valid;

    assign unused_wdata = ^wdata;

    always_comb begin
        clr = '0;
        if (wr_ev && offset == INTC_PENDING) clr = wdata[N_IRQ-1:0] & edge_en;
        if (wr_ev && offset == INTC_EDGE)    clr = ~wdata[N_IRQ-1:0];
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (ack_ev && idx == 4'(i)) clr[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            mask    <= '0;
            edge_en <= '0;
            latch   <= '0;
        end else begin
            nrd_q <= nrd;
            nwr_q <= nwr;
            // A same-cycle edge wins over every clear source.
            latch <= (latch & ~clr) | (rise & edge_en);
            if (wr_ev && offset == INTC_MASK) mask    <= wdata[N_IRQ-1:0];
            if (wr_ev && offset == INTC_EDGE) edge_en <= wdata[N_IRQ-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                INTC_PENDING: rdata = 16'(pending);
                INTC_MASK:    rdata = 16'(mask);
                INTC_EDGE:    rdata = 16'(edge_en);
                INTC_VECTOR: begin
                    rdata[INTC_VALID_BIT] = valid;
                    rdata[3:0]            = idx;
                end
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny16_intc.sv
// Self-checking bench for tiny16_intc: directed scenarios plus random bus and
// irq traffic compared each cycle against a behavioural model.
module tb_tiny16_intc;

    localparam int          N     = 8;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] NMASK = 16'h00FF;

    logic         clk = 1'b0;
    logic         nreset;
    logic [15:0]  address;
    logic [15:0]  wdata;
    logic         nrd;
    logic         nwr;
    logic [15:0]  rdata;
    logic         sel;
    logic [N-1:0] irq;
    logic         interrupt;

    tiny16_intc #(.N_IRQ(N), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .address   (address),
        .wdata     (wdata),
        .nrd       (nrd),
        .nwr       (nwr),
        .rdata     (rdata),
        .sel       (sel),
        .irq       (irq),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: irq samples by age, per-source latch, mask, mode.
    logic [15:0] seen [3];
    logic [15:0] m_mask, m_edge, m_latch;
    bit          m_nrd_q, m_nwr_q;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) seen[i] = '0;
        m_mask  = '0;
        m_edge  = '0;
        m_latch = '0;
        m_nrd_q = 1'b1;
        m_nwr_q = 1'b1;
    endtask

    function automatic logic [15:0] m_pending();
        logic [15:0] p;
        p = '0;
        // A source's synchronised level is the irq seen two edges ago.
        for (int i = 0; i < N; i++) p[i] = m_edge[i] ? m_latch[i] : seen[1][i];
        return p;
    endfunction

    function automatic logic [15:0] m_vector();
        logic [15:0] act;
        act = m_pending() & m_mask;
        for (int i = 0; i < 16; i++) if (act[i]) return 16'h8000 + 16'(i);
        return 16'h0000;
    endfunction

    function automatic bit in_window(input logic [15:0] a);
        return (a >> 2) == (BASE >> 2);
    endfunction

    function automatic logic [15:0] m_rdata();
        if (!in_window(address)) return 16'h0000;
        case (address - BASE)
            16'd0:   return m_pending();
            16'd1:   return m_mask;
            16'd2:   return m_edge;
            default: return m_vector();
        endcase
    endfunction

    task automatic model_step();
        logic [15:0] vec;
        logic [15:0] off;
        bit          wr_hit, rd_hit, rose, cleared;
        vec    = m_vector();
        off    = address - BASE;
        wr_hit = in_window(address) && !nwr && m_nwr_q;
        rd_hit = in_window(address) && !nrd && m_nrd_q && off == 16'd3 && vec[15];
        for (int i = 0; i < N; i++) begin
            rose    = seen[1][i] && !seen[2][i];
            cleared = (wr_hit && off == 16'd0 && wdata[i] && m_edge[i])
                   || (wr_hit && off == 16'd2 && !wdata[i])
                   || (rd_hit && int'(vec[3:0]) == i);
            if (m_edge[i] && rose) m_latch[i] = 1'b1;
            else if (cleared)      m_latch[i] = 1'b0;
        end
        if (wr_hit && off == 16'd1) m_mask = wdata & NMASK;
        if (wr_hit && off == 16'd2) m_edge = wdata & NMASK;
        seen[2] = seen[1];
        seen[1] = seen[0];
        seen[0] = 16'(irq);
        m_nrd_q = nrd;
        m_nwr_q = nwr;
    endtask

    task automatic check_model();
        check("sel", 16'(sel), 16'(in_window(address)));
        check("rdata", rdata, m_rdata());
        check("interrupt", 16'(interrupt), 16'(|(m_pending() & m_mask)));
    endtask

    task automatic tick();
        #1;
        check_model();
        if (!nreset) model_reset();
        else         model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        wdata   = d;
        nwr     = 1'b0;
        tick();
        nwr = 1'b1;
        tick();
    endtask

    task automatic bus_read(input logic [15:0] a, input string tag, input logic [15:0] exp, input bit directed);
        address = a;
        nrd     = 1'b0;
        #1;
        if (directed) check(tag, rdata, exp);
        tick();
        nrd = 1'b1;
        tick();
    endtask

    task automatic pulse_irq(input logic [N-1:0] bits);
        irq = bits;
        tick();
        irq = '0;
        repeat (3) tick();
    endtask

    initial begin
        model_reset();
        nreset  = 1'b0;
        address = '0;
        wdata   = '0;
        nrd     = 1'b1;
        nwr     = 1'b1;
        irq     = '0;
        repeat (3) tick();
        check("rst_interrupt", 16'(interrupt), 16'h0000);
        address = BASE + 16'd1;
        #1;
        check("rst_mask", rdata, 16'h0000);
        address = '0;
        nreset  = 1'b1;
        repeat (2) tick();

        // Level mode
        bus_write(BASE + 16'd1, 16'h00FF);
        bus_write(BASE + 16'd2, 16'h0000);
        irq = 8'h08;
        tick();
        check("lvl_int_k", 16'(interrupt), 16'h0000);
        tick();
        check("lvl_int_k1", 16'(interrupt), 16'h0001);
        bus_read(BASE + 16'd3, "lvl_vector", 16'h8003, 1'b1);
        irq = '0;
        tick();
        check("lvl_fall_1", 16'(interrupt), 16'h0001);
        tick();
        check("lvl_fall_2", 16'(interrupt), 16'h0000);

        // Edge ack
        bus_write(BASE + 16'd2, 16'h00FF);
        pulse_irq(8'h20);
        check("edge_int", 16'(interrupt), 16'h0001);
        bus_read(BASE + 16'd0, "edge_pending", 16'h0020, 1'b1);
        bus_read(BASE + 16'd3, "edge_vec1", 16'h8005, 1'b1);
        check("edge_int_acked", 16'(interrupt), 16'h0000);
        bus_read(BASE + 16'd3, "edge_vec2", 16'h0000, 1'b1);

        // Priority
        pulse_irq(8'h44);
        bus_read(BASE + 16'd3, "prio_1", 16'h8002, 1'b1);
        bus_read(BASE + 16'd3, "prio_2", 16'h8006, 1'b1);
        bus_read(BASE + 16'd3, "prio_3", 16'h0000, 1'b1);

        // Masking and W1C
        bus_write(BASE + 16'd1, 16'h0000);
        pulse_irq(8'h02);
        check("masked_int", 16'(interrupt), 16'h0000);
        bus_read(BASE + 16'd0, "masked_pending", 16'h0002, 1'b1);
        bus_write(BASE + 16'd1, 16'h0002);
        check("unmasked_int", 16'(interrupt), 16'h0001);
        bus_write(BASE + 16'd0, 16'h0002);
        check("w1c_int", 16'(interrupt), 16'h0000);

        // Edge set colliding with the ack of the same index
        bus_write(BASE + 16'd1, 16'h00FF);
        pulse_irq(8'h10);
        irq = 8'h10;
        tick();
        tick();
        address = BASE + 16'd3;
        nrd     = 1'b0;
        #1;
        check("coll_vector", rdata, 16'h8004);
        tick();
        nrd = 1'b1;
        tick();
        bus_read(BASE + 16'd0, "coll_pending", 16'h0010, 1'b1);
        irq = '0;
        bus_write(BASE + 16'd0, 16'h0010);
        repeat (2) tick();

        // Held write strobe updates once
        address = BASE + 16'd1;
        wdata   = 16'h0055;
        nwr     = 1'b0;
        tick();
        wdata = 16'h00AA;
        tick();
        tick();
        nwr = 1'b1;
        tick();
        bus_read(BASE + 16'd1, "held_write", 16'h0055, 1'b1);

        // Outside the window
        address = BASE + 16'd4;
        #1;
        check("outside_sel", 16'(sel), 16'h0000);
        bus_write(BASE + 16'd4, 16'h00F0);
        bus_write(BASE + 16'd5, 16'h00F0);
        bus_read(BASE + 16'd1, "outside_mask", 16'h0055, 1'b1);

        // Reset during a write
        address = BASE + 16'd1;
        wdata   = 16'h00FF;
        nwr     = 1'b0;
        #2;
        nreset = 1'b0;
        model_reset();
        tick();
        nwr = 1'b1;
        tick();
        nreset = 1'b1;
        tick();
        bus_read(BASE + 16'd1, "rst_mid_write", 16'h0000, 1'b1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int unsigned op;
            logic [15:0] a;
            if ($urandom_range(3) == 0) irq = irq ^ N'(1 << $urandom_range(N - 1));
            a  = BASE + 16'($urandom_range(4));
            op = $urandom_range(9);
            if (op < 2)      bus_write(a, 16'($urandom));
            else if (op < 5) bus_read(a, "rand_read", 16'h0000, 1'b0);
            else             tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
